usb_tx_serializer: RTL



---
 rtl/usb_tx_pkg.sv | 16 +
 rtl/usb_tx_bit_timer.sv | 35 +++
 rtl/usb_tx_serializer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit serializer.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_DATA = 3'd2,
    ST_EOP  = 3'd3,
    ST_JBIT = 3'd4
  } tx_state_t;

  localparam logic [7:0]  SYNC_BYTE   = 8'h80;
  localparam int unsigned STUFF_LIMIT = 6;
  localparam int unsigned EOP_BITS    = 2;

endpackage

// File: rtl/usb_tx_bit_timer.sv
// Bit-period counter; flag_8 is a registered decode of the last count of each bit time.
module usb_tx_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic run,
  output logic flag_8
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Counter is parked at zero whenever the serializer is idle.
  always_comb begin
    count_d = '0;
    if (run) begin
      count_d = (count_q == LAST_CNT) ? '0 : count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
      flag_8  <= 1'b0;
    end else begin
      count_q <= count_d;
      flag_8  <= run && (count_d == LAST_CNT);
    end
  end

endmodule

// File: rtl/usb_tx_serializer.sv
// USB TX serializer: SYNC + LSB-first data with bit stuffing, then EOP and a closing J,
// feeding the downstream NRZI encoder's d_orig/pause/eop/flag_8 inputs.
module usb_tx_serializer
  import usb_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_error,
  output logic       flag_8,
  output logic       d_orig,
  output logic       pause,
  output logic       eop
);

  localparam int unsigned STUFF_W = $clog2(STUFF_LIMIT + 1);
  localparam int unsigned EOP_W   = (EOP_BITS > 1) ? $clog2(EOP_BITS) : 1;

  tx_state_t         state_q, state_d;
  logic [7:0]        shift_q, shift_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [STUFF_W-1:0] ones_q, ones_d;
  logic [EOP_W-1:0]  eop_cnt_q, eop_cnt_d;
  logic              last_q, last_d;
  logic              d_orig_q, d_orig_d;
  logic              pause_q, pause_d;
  logic              eop_q, eop_d;
  logic              tx_error_q, tx_error_d;
  logic              tx_busy_q;
  logic              stuff_due;

  usb_tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk   (clk),
    .n_rst (n_rst),
    .run   (state_q != ST_IDLE),
    .flag_8(flag_8)
  );

  assign stuff_due = (ones_q == STUFF_W'(STUFF_LIMIT));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      ones_q     <= '0;
      eop_cnt_q  <= '0;
      last_q     <= 1'b0;
      d_orig_q   <= 1'b1;
      pause_q    <= 1'b1;
      eop_q      <= 1'b0;
      tx_error_q <= 1'b0;
      tx_busy_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      ones_q     <= ones_d;
      eop_cnt_q  <= eop_cnt_d;
      last_q     <= last_d;
      d_orig_q   <= d_orig_d;
      pause_q    <= pause_d;
      eop_q      <= eop_d;
      tx_error_q <= tx_error_d;
      tx_busy_q  <= (state_d != ST_IDLE);
    end
  end

  // Next-state logic; line outputs only move on a bit strobe (except the idle start).
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    ones_d     = ones_q;
    eop_cnt_d  = eop_cnt_q;
    last_d     = last_q;
    d_orig_d   = d_orig_q;
    pause_d    = pause_q;
    eop_d      = eop_q;
    tx_error_d = 1'b0;
    tx_ready   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (tx_valid) begin
          state_d   = ST_SYNC;
          shift_d   = SYNC_BYTE;
          d_orig_d  = SYNC_BYTE[0];
          pause_d   = 1'b0;
          eop_d     = 1'b0;
          bit_idx_d = '0;
          ones_d    = '0;
          last_d    = 1'b0;
        end
      end

      ST_SYNC, ST_DATA: begin
        if (flag_8) begin
          if (stuff_due) begin
            // Stuff slot: hold the byte position, break the run of ones.
            d_orig_d = 1'b0;
            ones_d   = '0;
          end else if (bit_idx_q != 3'd7) begin
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + 3'd1;
            d_orig_d  = shift_q[1];
            ones_d    = shift_q[1] ? ones_q + STUFF_W'(1) : '0;
          end else if ((state_q == ST_SYNC) || !last_q) begin
            tx_ready = 1'b1;
            if (tx_valid) begin
              state_d   = ST_DATA;
              shift_d   = tx_data;
              last_d    = tx_last;
              bit_idx_d = '0;
              d_orig_d  = tx_data[0];
              ones_d    = tx_data[0] ? ones_q + STUFF_W'(1) : '0;
            end else begin
              tx_error_d = 1'b1;
              eop_d      = 1'b1;
              eop_cnt_d  = '0;
              state_d    = ST_EOP;
            end
          end else begin
            eop_d     = 1'b1;
            eop_cnt_d = '0;
            state_d   = ST_EOP;
          end
        end
      end

      ST_EOP: begin
        if (flag_8) begin
          if (eop_cnt_q == EOP_W'(EOP_BITS - 1)) begin
            eop_d   = 1'b0;
            state_d = ST_JBIT;
          end else begin
            eop_cnt_d = eop_cnt_q + EOP_W'(1);
          end
        end
      end

      ST_JBIT: begin
        if (flag_8) begin
          pause_d = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign d_orig   = d_orig_q;
  assign pause    = pause_q;
  assign eop      = eop_q;
  assign tx_error = tx_error_q;
  assign tx_busy  = tx_busy_q;

endmodule
